// File: rtl/spi_master_pkg.sv
// Shared types for the SPI / 3-wire master controller.
// Holds the transaction state encoding and a small sizing helper.
package spi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_STOP  = 3'd4
    } spi_state_e;

    function automatic int max_width(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Command/response bus between a register block (master side) and the
// SPI controller (slave side).
interface spi_master_ctrl_if #(
    parameter int MOSI_DATA_WIDTH = 8,
    parameter int MISO_DATA_WIDTH = 8
) ();

    logic                       spi_wr_cmd;
    logic                       spi_rd_cmd;
    logic                       spi_busy;
    logic [MOSI_DATA_WIDTH-1:0] mosi_data;
    logic [MISO_DATA_WIDTH-1:0] miso_data;

    modport master (
        output spi_wr_cmd,
        output spi_rd_cmd,
        output mosi_data,
        input  spi_busy,
        input  miso_data
    );

    modport slave (
        input  spi_wr_cmd,
        input  spi_rd_cmd,
        input  mosi_data,
        output spi_busy,
        output miso_data
    );

endinterface

// File: rtl/spi_master_ctrl_edge_detect.sv
// Rising-edge detector: one-cycle pulse when i_sig goes from 0 to 1,
// judged against the value registered on the previous clk edge.
module edge_detect (
    input  logic clk,
    input  logic nrst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    // Remember last cycle's level of the watched signal
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI / 3-wire master: shifts out a command word and optionally reads back a
// response word on the shared data line, paced by ticks of the spi_clk prescaler.
module spi_master_ctrl
    import spi_master_pkg::*;
#(
    parameter logic CPOL                 = 1'b0,
    parameter logic FREE_RUNNING_SPI_CLK = 1'b0,
    parameter int   MOSI_DATA_WIDTH      = 8,
    parameter logic WRITE_MSB_FIRST      = 1'b1,
    parameter int   MISO_DATA_WIDTH      = 8,
    parameter logic READ_MSB_FIRST       = 1'b1
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               spi_clk,
    spi_master_ctrl_if.slave   bus,
    output logic               clk_pin,
    output logic               ncs_pin,
    output logic               mosi_pin,
    output logic               oe_pin,
    input  logic               miso_pin
);

    localparam int CNT_W = $clog2(max_width(MOSI_DATA_WIDTH, MISO_DATA_WIDTH) + 1);
    localparam logic [CNT_W-1:0] LAST_WR_BIT = CNT_W'(MOSI_DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_RD_BIT = CNT_W'(MISO_DATA_WIDTH - 1);

    spi_state_e                 r_state;
    logic                       r_phase;
    logic                       r_is_read;
    logic [MOSI_DATA_WIDTH-1:0] r_tx;
    logic [MISO_DATA_WIDTH-1:0] r_rx;
    logic [CNT_W-1:0]           r_bit_cnt;
    logic                       r_clk_pin;
    logic                       r_ncs;
    logic                       r_mosi;
    logic                       r_oe;
    logic                       r_busy;
    logic [MISO_DATA_WIDTH-1:0] r_miso_data;

    logic                       w_tick;
    logic                       w_accept;
    logic                       w_shift_active;
    logic                       w_tx_head;
    logic [MOSI_DATA_WIDTH-1:0] w_tx_shifted;
    logic [MISO_DATA_WIDTH-1:0] w_rx_next;

    edge_detect u_tick (
        .clk    (clk),
        .nrst   (nrst),
        .i_sig  (spi_clk),
        .o_rise (w_tick)
    );

    assign w_accept       = bus.spi_wr_cmd | bus.spi_rd_cmd;
    assign w_shift_active = (r_state == ST_WRITE) || (r_state == ST_READ);

    // The bit on the wire is always the head of r_tx; shifting exposes the next one
    assign w_tx_head    = WRITE_MSB_FIRST ? r_tx[MOSI_DATA_WIDTH-1] : r_tx[0];
    assign w_tx_shifted = WRITE_MSB_FIRST ? (r_tx << 1) : (r_tx >> 1);
    assign w_rx_next    = READ_MSB_FIRST
                        ? ((r_rx << 1) | MISO_DATA_WIDTH'(miso_pin))
                        : ((r_rx >> 1) | (MISO_DATA_WIDTH'(miso_pin) << (MISO_DATA_WIDTH - 1)));

    // Transaction FSM with registered pins, shift registers and bit counter
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state     <= ST_IDLE;
            r_phase     <= 1'b0;
            r_is_read   <= 1'b0;
            r_tx        <= {MOSI_DATA_WIDTH{1'b0}};
            r_rx        <= {MISO_DATA_WIDTH{1'b0}};
            r_bit_cnt   <= {CNT_W{1'b0}};
            r_clk_pin   <= CPOL;
            r_ncs       <= 1'b1;
            r_mosi      <= 1'b0;
            r_oe        <= 1'b0;
            r_busy      <= 1'b0;
            r_miso_data <= {MISO_DATA_WIDTH{1'b0}};
        end else begin
            // clk_pin follows the next phase; in gated mode only the shift states open the gate
            if (w_tick) begin
                r_phase   <= ~r_phase;
                r_clk_pin <= CPOL ^ (~r_phase & (FREE_RUNNING_SPI_CLK | w_shift_active));
            end else begin
                r_phase   <= r_phase;
                r_clk_pin <= r_clk_pin;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state   <= ST_START;
                        r_busy    <= 1'b1;
                        r_is_read <= bus.spi_rd_cmd;
                        r_tx      <= bus.mosi_data;
                        r_rx      <= {MISO_DATA_WIDTH{1'b0}};
                    end else begin
                        r_state   <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (w_tick && r_phase) begin
                        r_ncs     <= 1'b0;
                        r_oe      <= 1'b1;
                        r_mosi    <= w_tx_head;
                        r_tx      <= w_tx_shifted;
                        r_bit_cnt <= {CNT_W{1'b0}};
                        r_state   <= ST_WRITE;
                    end else begin
                        r_state   <= ST_START;
                    end
                end
                ST_WRITE: begin
                    // Only trailing edges (phase returning to 0) matter while writing
                    if (w_tick && r_phase) begin
                        if (r_bit_cnt == LAST_WR_BIT) begin
                            r_bit_cnt <= {CNT_W{1'b0}};
                            if (r_is_read) begin
                                r_oe    <= 1'b0;
                                r_mosi  <= 1'b0;
                                r_state <= ST_READ;
                            end else begin
                                r_state <= ST_STOP;
                            end
                        end else begin
                            r_mosi    <= w_tx_head;
                            r_tx      <= w_tx_shifted;
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_state <= ST_WRITE;
                    end
                end
                ST_READ: begin
                    if (w_tick) begin
                        if (!r_phase) begin
                            r_rx <= w_rx_next;
                        end else if (r_bit_cnt == LAST_RD_BIT) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_state <= ST_READ;
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_ncs   <= 1'b1;
                        r_oe    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                        if (r_is_read) begin
                            r_miso_data <= r_rx;
                        end else begin
                            r_miso_data <= r_miso_data;
                        end
                    end else begin
                        r_state <= ST_STOP;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ncs   <= 1'b1;
                    r_oe    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign clk_pin       = r_clk_pin;
    assign ncs_pin       = r_ncs;
    assign mosi_pin      = r_mosi;
    assign oe_pin        = r_oe;
    assign bus.spi_busy  = r_busy;
    assign bus.miso_data = r_miso_data;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: three configurations (gated CPOL=0 MSB, gated CPOL=1 MSB,
// free-running CPOL=0 LSB) driven by directed and random transactions against a word-level model.
`timescale 1ns/1ps
module tb_spi_master_ctrl;

    localparam int N = 8;
    localparam int M = 8;
    localparam int NDUT = 3;
    localparam logic [2:0] CPOL_V = 3'b010;
    localparam logic [2:0] FREE_V = 3'b100;
    localparam logic [2:0] WMSB_V = 3'b011;
    localparam logic [2:0] RMSB_V = 3'b011;

    logic       clk = 1'b0;
    logic       spi_clk = 1'b0;
    logic       nrst;
    logic [2:0] wr_v, rd_v, clk_pin_v, ncs_v, mosi_v, oe_v, miso_v, busy_v;
    logic [7:0] data_a [NDUT];
    logic [7:0] rxd_a  [NDUT];
    logic [7:0] exp_miso [NDUT];
    int         half = 1;
    int         div_cnt = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    spi_master_ctrl_if #(.MOSI_DATA_WIDTH(N), .MISO_DATA_WIDTH(M)) if0 ();
    spi_master_ctrl_if #(.MOSI_DATA_WIDTH(N), .MISO_DATA_WIDTH(M)) if1 ();
    spi_master_ctrl_if #(.MOSI_DATA_WIDTH(N), .MISO_DATA_WIDTH(M)) if2 ();

    assign if0.spi_wr_cmd = wr_v[0];
    assign if0.spi_rd_cmd = rd_v[0];
    assign if0.mosi_data  = data_a[0];
    assign busy_v[0]      = if0.spi_busy;
    assign rxd_a[0]       = if0.miso_data;
    assign if1.spi_wr_cmd = wr_v[1];
    assign if1.spi_rd_cmd = rd_v[1];
    assign if1.mosi_data  = data_a[1];
    assign busy_v[1]      = if1.spi_busy;
    assign rxd_a[1]       = if1.miso_data;
    assign if2.spi_wr_cmd = wr_v[2];
    assign if2.spi_rd_cmd = rd_v[2];
    assign if2.mosi_data  = data_a[2];
    assign busy_v[2]      = if2.spi_busy;
    assign rxd_a[2]       = if2.miso_data;

    spi_master_ctrl #(.CPOL(1'b0), .FREE_RUNNING_SPI_CLK(1'b0), .MOSI_DATA_WIDTH(N),
                      .WRITE_MSB_FIRST(1'b1), .MISO_DATA_WIDTH(M), .READ_MSB_FIRST(1'b1)) u_dut0 (
        .clk(clk), .nrst(nrst), .spi_clk(spi_clk), .bus(if0),
        .clk_pin(clk_pin_v[0]), .ncs_pin(ncs_v[0]), .mosi_pin(mosi_v[0]),
        .oe_pin(oe_v[0]), .miso_pin(miso_v[0]));

    spi_master_ctrl #(.CPOL(1'b1), .FREE_RUNNING_SPI_CLK(1'b0), .MOSI_DATA_WIDTH(N),
                      .WRITE_MSB_FIRST(1'b1), .MISO_DATA_WIDTH(M), .READ_MSB_FIRST(1'b1)) u_dut1 (
        .clk(clk), .nrst(nrst), .spi_clk(spi_clk), .bus(if1),
        .clk_pin(clk_pin_v[1]), .ncs_pin(ncs_v[1]), .mosi_pin(mosi_v[1]),
        .oe_pin(oe_v[1]), .miso_pin(miso_v[1]));

    spi_master_ctrl #(.CPOL(1'b0), .FREE_RUNNING_SPI_CLK(1'b1), .MOSI_DATA_WIDTH(N),
                      .WRITE_MSB_FIRST(1'b0), .MISO_DATA_WIDTH(M), .READ_MSB_FIRST(1'b0)) u_dut2 (
        .clk(clk), .nrst(nrst), .spi_clk(spi_clk), .bus(if2),
        .clk_pin(clk_pin_v[2]), .ncs_pin(ncs_v[2]), .mosi_pin(mosi_v[2]),
        .oe_pin(oe_v[2]), .miso_pin(miso_v[2]));

    initial forever #5 clk = ~clk;

    // Prescaler square wave: period 2*half clk cycles
    always @(posedge clk) begin
        if (div_cnt >= half - 1) begin
            div_cnt <= 0;
            spi_clk <= ~spi_clk;
        end else begin
            div_cnt <= div_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave sends its word MSB first; the master places bit i of that stream by its read order
    function automatic logic [7:0] model_rx(input logic [7:0] sw, input bit msb);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (msb) r[7-i] = sw[7-i];
            else     r[i]   = sw[7-i];
        end
        return r;
    endfunction

    task automatic set_div(input int h);
        half = h;
        repeat (12) @(negedge clk);
    endtask

    task automatic check_reset_state(input int g);
        check_eq("rst_ncs",  ncs_v[g], 1'b1);
        check_eq("rst_oe",   oe_v[g], 1'b0);
        check_eq("rst_mosi", mosi_v[g], 1'b0);
        check_eq("rst_clk",  clk_pin_v[g], CPOL_V[g]);
        check_eq("rst_busy", busy_v[g], 1'b0);
        check_eq("rst_miso", rxd_a[g], 8'h00);
    endtask

    task automatic run_txn(input int g, input bit rd, input bit wr, input logic [7:0] d,
                           input logic [7:0] sw, input bit poke, input bit abort);
        bit   done, aborted, exp_rd;
        int   low_cnt, trail, lead_rd, gate_err;
        logic c, n, o, prev_c, prev_n;
        bit   tx_q[$];
        done = 0; aborted = 0; exp_rd = rd;
        low_cnt = 0; trail = 0; lead_rd = 0; gate_err = 0;
        miso_v[g] = 1'b0;
        @(negedge clk);
        data_a[g] = d; wr_v[g] = wr; rd_v[g] = rd;
        @(negedge clk);
        wr_v[g] = 1'b0; rd_v[g] = 1'b0; data_a[g] = ~d;
        check_eq("busy_rise", busy_v[g], 1'b1);
        prev_c = clk_pin_v[g]; prev_n = ncs_v[g];
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(negedge clk);
            c = clk_pin_v[g]; n = ncs_v[g]; o = oe_v[g];
            if (!FREE_V[g] && n && (c !== CPOL_V[g])) gate_err++;
            if (!n) low_cnt++;
            if (!n && !prev_n) begin
                if (prev_c == CPOL_V[g] && c != CPOL_V[g]) begin
                    if (o) tx_q.push_back(mosi_v[g]);
                    else   lead_rd++;
                end
                if (prev_c != CPOL_V[g] && c == CPOL_V[g]) begin
                    trail++;
                    if (exp_rd && trail >= N && trail < N + M) miso_v[g] = sw[7-(trail-N)];
                    if (abort && trail == 3) begin
                        nrst = 1'b0;
                        @(negedge clk);
                        check_reset_state(g);
                        nrst = 1'b1;
                        for (int k = 0; k < NDUT; k++) exp_miso[k] = 8'h00;
                        aborted = 1; done = 1;
                    end
                end
            end
            if (poke && cyc == 24) begin
                rd_v[g] = 1'b1; wr_v[g] = 1'b1; data_a[g] = 8'h00;
            end else if (poke && cyc == 25) begin
                rd_v[g] = 1'b0; wr_v[g] = 1'b0;
            end
            if (!aborted && !prev_n && n) begin
                done = 1;
                check_eq("busy_fall", busy_v[g], 1'b0);
            end
            prev_c = c; prev_n = n;
        end
        rd_v[g] = 1'b0; wr_v[g] = 1'b0;
        check_eq("done", done, 1'b1);
        if (done && !aborted) begin
            check_eq("tx_len", tx_q.size(), N);
            if (tx_q.size() == N) begin
                for (int k = 0; k < N; k++)
                    check_eq("tx_bit", tx_q[k], WMSB_V[g] ? d[7-k] : d[k]);
            end
            check_eq("rd_bits", lead_rd, exp_rd ? M : 0);
            check_eq("ncs_low", low_cnt, (2 * (N + (exp_rd ? M : 0)) + 1) * 2 * half);
            check_eq("gate_idle", gate_err, 0);
            if (exp_rd) exp_miso[g] = model_rx(sw, RMSB_V[g]);
            repeat (10) @(negedge clk);
            check_eq("miso_data", rxd_a[g], exp_miso[g]);
            check_eq("stay_idle", {busy_v[g], ncs_v[g]}, 2'b01);
        end
    endtask

    initial begin
        int idle_toggles, gate_bad, k;
        logic last_c;
        nrst = 1'b0; wr_v = 3'b000; rd_v = 3'b000; miso_v = 3'b000;
        for (int g = 0; g < NDUT; g++) begin
            data_a[g] = 8'h00;
            exp_miso[g] = 8'h00;
        end
        repeat (4) @(negedge clk);
        for (int g = 0; g < NDUT; g++) check_reset_state(g);
        nrst = 1'b1;
        set_div(1);

        run_txn(0, 1'b1, 1'b0, 8'hA3, 8'hA3, 1'b0, 1'b0);
        run_txn(1, 1'b1, 1'b0, 8'hA3, 8'hA3, 1'b0, 1'b0);
        run_txn(2, 1'b1, 1'b0, 8'hA3, 8'hA3, 1'b0, 1'b0);
        check_eq("lsb_word", rxd_a[2], 8'hC5);

        // Idle behaviour: free-running clock toggles, gated clocks rest at CPOL
        idle_toggles = 0; gate_bad = 0; last_c = clk_pin_v[2];
        repeat (24) begin
            @(negedge clk);
            if (clk_pin_v[2] != last_c) idle_toggles++;
            last_c = clk_pin_v[2];
            if (clk_pin_v[0] !== 1'b0 || clk_pin_v[1] !== 1'b1) gate_bad++;
        end
        check_eq("free_toggle", (idle_toggles > 0), 1'b1);
        check_eq("gated_rest", gate_bad, 0);

        run_txn(0, 1'b0, 1'b1, 8'h5A, 8'hFF, 1'b0, 1'b0);
        run_txn(1, 1'b1, 1'b1, 8'h3C, 8'h96, 1'b1, 1'b0);

        for (int i = 0; i < 18; i++) begin
            int g, kind;
            g = $urandom_range(0, 2);
            kind = $urandom_range(0, 2);
            set_div($urandom_range(1, 3));
            run_txn(g, (kind != 0), (kind != 1), 8'($urandom), 8'($urandom),
                    1'($urandom_range(0, 1)), 1'b0);
        end

        set_div(2);
        run_txn(0, 1'b1, 1'b0, 8'hA3, 8'h81, 1'b0, 1'b0);
        run_txn(0, 1'b1, 1'b0, 8'h77, 8'h55, 1'b0, 1'b1);
        for (k = 1; k < NDUT; k++) check_eq("rst_other", rxd_a[k], 8'h00);
        run_txn(0, 1'b1, 1'b0, 8'h19, 8'hE4, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Single-clock SPI / 3-wire master that shifts out a command word and optionally reads a response word over a shared data line. Serial timing derives from an externally supplied prescaler clock `spi_clk`, which is sampled in the `clk` domain. The block sits between a register or command interface and the FPGA pins (`clk_pin`, `ncs_pin`, `mosi_pin`, `oe_pin`, `miso_pin`).

## Interface
- `CPOL`, 0: idle level of `clk_pin`.
- `FREE_RUNNING_SPI_CLK`, 0:
  - 1 = `clk_pin` toggles continuously.
  - 0 = `clk_pin` toggles only while `ncs_pin` is low.
- `MOSI_DATA_WIDTH`, 8: bits written per transaction.
- `WRITE_MSB_FIRST`, 1: 1 = MSB first on `mosi_pin`, 0 = LSB first.
- `MISO_DATA_WIDTH`, 8: bits read per read transaction.
- `READ_MSB_FIRST`, 1: 1 = first received bit lands in the MSB, 0 = first received bit lands in bit 0.

Ports:
- `clk` in 1: system clock.
- `nrst` in 1: one clock; reset is synchronous and active-low.
- `spi_clk` in 1: prescaler square wave, synchronous to `clk`, at most `clk`/2.
- `spi_wr_cmd` in 1: start a write-only transaction.
- `spi_rd_cmd` in 1: start a write-then-read transaction.
- `spi_busy` out 1: transaction in progress.
- `mosi_data` in `MOSI_DATA_WIDTH`: word to transmit, latched at command accept.
- `miso_data` out `MISO_DATA_WIDTH`: last received word.
- `clk_pin` out 1: SPI serial clock.
- `ncs_pin` out 1: chip select, active low.
- `mosi_pin` out 1: serial data out.
- `oe_pin` out 1: 1 = master drives the data line; 0 = slave may drive.
- `miso_pin` in 1: serial data in.

## Operation
- **Tick:** one `clk` cycle pulse on each `spi_clk` rising edge, detected with a registered previous value. All pin activity advances on ticks only.
- **Phase bit:** toggles on every tick. In free-running mode `clk_pin` = `CPOL` ^ `phase`; in gated mode `clk_pin` = `CPOL` ^ (`phase` & active).
- **Edge roles:**
  - Leading edge (`clk_pin` leaves `CPOL`): the master samples `miso_pin`.
  - Trailing edge: the master updates `mosi_pin`.
  - The slave changes its data on trailing edges (mode 0/2 style).
- **States:** IDLE → START → WRITE → (READ) → STOP → IDLE.
- **IDLE:**
  - A command is accepted on any `clk` edge where `spi_wr_cmd` or `spi_rd_cmd` is 1.
  - If both are high, read wins.
  - `mosi_data` and the command type are latched, and `spi_busy` rises the next cycle.
  - Commands arriving while busy are ignored.
- **START:** on the first tick where `phase` becomes 0 (`clk_pin` at `CPOL`):
  - `ncs_pin` goes to 0 and `oe_pin` to 1.
  - `mosi_pin` takes the first write bit.
- **WRITE:** `MOSI_DATA_WIDTH` bits, 2 ticks per bit (leading edge, then trailing edge). On each trailing edge except the last, `mosi_pin` takes the next bit.
- **Transition on the last trailing edge:**
  - Write command: go to STOP.
  - Read command: `oe_pin` goes to 0, `mosi_pin` to 0, and the state goes to READ.
- **READ:** `MISO_DATA_WIDTH` bits. On each leading edge `miso_pin` is shifted into the receive register in the order set by `READ_MSB_FIRST`.
- **STOP:** on the next tick:
  - `ncs_pin` goes to 1 and `oe_pin` to 0.
  - On read transactions, `miso_data` is updated with the received word.
  - `spi_busy` falls and the state returns to IDLE.
- **`miso_data` hold:** holds its value between read transactions and is unchanged by write transactions.
- **Reset values:** `ncs_pin`=1, `oe_pin`=0, `mosi_pin`=0, `clk_pin`=`CPOL`, `spi_busy`=0, `miso_data`=0, `phase`=0, state IDLE.
- **Reset mid-transfer:** `nrst` low aborts the transfer. On the next `clk` edge, `ncs_pin` rises and all outputs take their reset values.

## Timing
- **Gated mode:** `clk_pin` rests at `CPOL` whenever `ncs_pin`=1.
- **Duration:** let T = `spi_clk` period. A transaction lasts (1 + 2·(`MOSI_DATA_WIDTH` + `MISO_DATA_WIDTH` if read) + 1) T, plus at most 1 T alignment in free-running mode.
- **Example:** for `spi_clk` = `clk`/2 and 8+8 read, the transaction is 34 ticks, about 68 `clk` cycles.
- **Chip-select setup:** `ncs_pin` low precedes the first leading edge by 1 T.
- **Chip-select hold:** the last trailing edge precedes `ncs_pin` high by 1 T.
- **Sampling:** `miso_pin` is registered in the tick cycle of the leading edge. The slave's data therefore has close to a full half-bit to settle after the preceding trailing edge.

## Structure
- **Package `spi_master_pkg`:** holds the state enum (IDLE, START, WRITE, READ, STOP).
- **Counters:** the bit counter width is $clog2 of max(`MOSI_DATA_WIDTH`, `MISO_DATA_WIDTH`)+1.
- **Sub-module:** one, the existing `edge_detect`, used for the `spi_clk` rising-edge tick. Everything else is a single FSM with shift registers.

## Test plan
- **Gated read, MSB first:** `CPOL`=0, gated, MSB first, `mosi_data`=0xA3. Slave shifts 0xA3 MSB first on `clk_pin` falling edges while `oe_pin`=0.
  - `mosi_pin` sequence is 1,0,1,0,0,0,1,1.
  - `miso_data`=0xA3, and `spi_busy` falls with `ncs_pin` rising.
- **`CPOL`=1:** same as above, but the slave shifts on rising edges. `clk_pin` idles high and `miso_data`=0xA3.
- **Free-running, LSB first:** `CPOL`=0, free-running, LSB-first write and read. Slave sends 1,0,1,0,0,0,1,1.
  - `mosi_pin` sequence is 1,1,0,0,0,1,0,1.
  - `miso_data`=0xC5.
  - `clk_pin` toggles while idle.
- **Write-only:** `spi_wr_cmd` with 0x5A.
  - 8 bits are sent with `oe_pin`=1 throughout.
  - No read phase occurs and `miso_data` is unchanged.
  - The transaction lasts 18 ticks.
- **Command while busy / simultaneous commands:**
  - `spi_rd_cmd` pulsed again mid-transfer is ignored.
  - `spi_wr_cmd` and `spi_rd_cmd` asserted together runs a read.
- **Reset mid-transfer:** `nrst`=0 during WRITE. One `clk` later `ncs_pin`=1, `oe_pin`=0, `clk_pin`=`CPOL`, `spi_busy`=0, and `miso_data`=0.
